mux_161_serializer: RTL and testbench

Sequential front-end for the 16:1 dataflow multiplexer. Captures a 16-bit word, drives the mux select through all 16 positions one per enabled clock, and registers the mux output into a serial bit stream with a valid flag. It sits directly upstream of the 16:1 mux, generating `s` and holding `i`, and consumes the mux output `o` to produce its own registered serial output. A ready/load handshake and a one-cycle done pulse let a controller stream words back to back.

---
 rtl/mux_161_serializer_pkg.sv | 22 ++
 rtl/mux_161_serializer_dataflow2.sv | 13 +
 rtl/mux_161_serializer.sv | 84 ++++++++
 tb/tb_mux_161_serializer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mux_161_serializer_pkg.sv
// Shared definitions for the 16:1 mux serializer front-end.
package mux_161_serializer_pkg;

   localparam int WORD_W = 16;
   localparam int SEL_W  = 4;

   // Two-bit state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // First select position for a given bit order
   function automatic logic [SEL_W-1:0] sel_start(input logic msb_first);
      return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
   endfunction

   // Last select position for a given bit order
   function automatic logic [SEL_W-1:0] sel_end(input logic msb_first);
      return msb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
   endfunction

endpackage

// File: rtl/mux_161_serializer_dataflow2.sv
// 16:1 dataflow multiplexer: o is the bit of i addressed by s.
module mux_161_dataflow2
   import mux_161_serializer_pkg::*;
(
   input  logic [WORD_W-1:0] i,
   input  logic [SEL_W-1:0]  s,
   output logic              o
);

   // Pure combinational select, no state
   assign o = i[s];

endmodule

// File: rtl/mux_161_serializer.sv
// Sequential front-end for the 16:1 mux: captures a word, walks the select
// through all 16 positions and registers the mux output as a serial stream.
module mux_161_serializer
   import mux_161_serializer_pkg::*;
#(
   parameter logic MSB_FIRST = 1'b0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] din,
   input  logic              en,
   output logic              ready,
   output logic [SEL_W-1:0]  sel,
   output logic              sout,
   output logic              sout_valid,
   output logic              done
);

   localparam logic [SEL_W-1:0] SEL_START = sel_start(MSB_FIRST);
   localparam logic [SEL_W-1:0] SEL_END   = sel_end(MSB_FIRST);

   logic [1:0]        state;
   logic [WORD_W-1:0] hold;
   logic              mux_o;
   logic [SEL_W-1:0]  sel_next;

   mux_161_dataflow2 u_mux (
      .i (hold),
      .s (sel),
      .o (mux_o)
   );

   // Select step direction follows the configured bit order
   assign sel_next = MSB_FIRST ? sel - 1'b1 : sel + 1'b1;

   // Handshake and pulse outputs are plain decodes of the state register
   assign ready = (state == ST_IDLE);
   assign done  = (state == ST_DONE);

   // Control FSM, hold register, select counter and serial output flop
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         hold       <= '0;
         sel        <= SEL_START;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               sout_valid <= 1'b0;
               if (load) begin
                  hold  <= din;
                  sel   <= SEL_START;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (en) begin
                  sout       <= mux_o;
                  sout_valid <= 1'b1;
                  // The end position is emitted but sel is left on it
                  if (sel == SEL_END) state <= ST_DONE;
                  else                sel   <= sel_next;
               end else begin
                  sout_valid <= 1'b0;
               end
            end
            ST_DONE: begin
               sout_valid <= 1'b0;
               sel        <= SEL_START;
               state      <= ST_IDLE;
            end
            default: begin
               sout_valid <= 1'b0;
               sel        <= SEL_START;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_161_serializer.sv
// Scoreboard bench for mux_161_serializer (LSB-first and MSB-first instances).
module tb_mux_161_serializer;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load0 = 1'b0, en0 = 1'b0;
   logic [15:0] din0 = '0;
   logic        load1 = 1'b0, en1 = 1'b0;
   logic [15:0] din1 = '0;

   logic        ready0, sout0, vld0, done0;
   logic [3:0]  sel0;
   logic        ready1, sout1, vld1, done1;
   logic [3:0]  sel1;

   exp_t q0[$];
   exp_t q1[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   mux_161_serializer #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .load(load0), .din(din0), .en(en0),
      .ready(ready0), .sel(sel0), .sout(sout0), .sout_valid(vld0), .done(done0)
   );

   mux_161_serializer #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .load(load1), .din(din1), .en(en1),
      .ready(ready1), .sel(sel1), .sout(sout1), .sout_valid(vld1), .done(done1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance to just after the edge that starts cycle c
   task automatic at_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_word(input int which, input logic [15:0] seq);
      // seq[15] is the first bit expected on sout, seq[0] the last
      for (int k = 15; k >= 0; k--) begin
         if (which == 0) q0.push_back('{b: seq[k], last: (k == 0)});
         else            q1.push_back('{b: seq[k], last: (k == 0)});
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (vld0) begin
            if (q0.size() == 0) chk("dut0 unexpected bit", 1, 0);
            else begin
               e = q0.pop_front();
               chk("dut0 sout", sout0, e.b);
               chk("dut0 done with bit", done0, e.last);
            end
         end else chk("dut0 done without bit", done0, 0);
         if (vld1) begin
            if (q1.size() == 0) chk("dut1 unexpected bit", 1, 0);
            else begin
               e = q1.pop_front();
               chk("dut1 sout", sout1, e.b);
               chk("dut1 done with bit", done1, e.last);
            end
         end else chk("dut1 done without bit", done1, 0);
      end
   endtask

   initial begin
      int n;
      at_cycle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst ready0", ready0, 1);
      chk("rst sel0", sel0, 0);
      chk("rst sout0", sout0, 0);
      chk("rst vld0", vld0, 0);
      chk("rst done0", done0, 0);
      chk("rst sel1", sel1, 15);
      chk("rst ready1", ready1, 1);
      fork
         monitor();
      join_none

      // A5C3 LSB first, with an ignored load of 1234 mid-word
      at_cycle(6);
      n = cyc;
      load0 = 1; din0 = 16'hA5C3; en0 = 1;
      push_word(0, 16'b1100_0011_1010_0101);
      at_cycle(n + 1); load0 = 0; din0 = '0;
      @(negedge clk); chk("shift ready0", ready0, 0);
      at_cycle(n + 3); load0 = 1; din0 = 16'h1234;
      at_cycle(n + 4); load0 = 0; din0 = '0;
      at_cycle(n + 17);
      @(negedge clk);
      chk("a5c3 done", done0, 1);
      chk("a5c3 ready in done", ready0, 0);
      // Back-to-back 0F0F
      at_cycle(n + 18);
      load0 = 1; din0 = 16'h0F0F;
      push_word(0, 16'b1111_0000_1111_0000);
      @(negedge clk); chk("a5c3 ready after done", ready0, 1);
      at_cycle(n + 19); load0 = 0; din0 = '0;
      @(negedge clk); chk("0f0f no bit yet", vld0, 0);
      at_cycle(n + 20);
      @(negedge clk); chk("0f0f first bit", vld0, 1);
      at_cycle(n + 35);
      @(negedge clk); chk("0f0f done", done0, 1);
      at_cycle(n + 36);
      @(negedge clk); chk("0f0f ready", ready0, 1);

      // FFFF with a 3-cycle stall after the 5th bit
      at_cycle(n + 40);
      n = cyc;
      load0 = 1; din0 = 16'hFFFF; en0 = 1;
      push_word(0, 16'hFFFF);
      at_cycle(n + 1); load0 = 0;
      at_cycle(n + 6); en0 = 0;
      @(negedge clk); chk("stall 5th bit", vld0, 1);
      for (int k = 7; k <= 9; k++) begin
         at_cycle(n + k);
         if (k == 9) en0 = 1;
         @(negedge clk);
         chk("stall vld", vld0, 0);
         chk("stall sel", sel0, 5);
      end
      at_cycle(n + 19);
      @(negedge clk); chk("stall no early done", done0, 0);
      at_cycle(n + 20);
      @(negedge clk); chk("stall done", done0, 1);
      chk("stall queue drained", q0.size(), 0);

      // Reset mid-word
      at_cycle(n + 24);
      n = cyc;
      load0 = 1; din0 = 16'hFFFF; en0 = 1;
      for (int k = 0; k < 7; k++) q0.push_back('{b: 1'b1, last: 1'b0});
      at_cycle(n + 1); load0 = 0;
      at_cycle(n + 8); rst = 1;
      at_cycle(n + 9); rst = 0;
      @(negedge clk);
      chk("abort sout", sout0, 0);
      chk("abort vld", vld0, 0);
      chk("abort ready", ready0, 1);
      chk("abort sel", sel0, 0);
      chk("abort done", done0, 0);
      at_cycle(n + 30);
      chk("abort queue drained", q0.size(), 0);

      // MSB first, 8001
      n = cyc;
      load1 = 1; din1 = 16'h8001; en1 = 1;
      push_word(1, 16'b1000_0000_0000_0001);
      at_cycle(n + 1); load1 = 0;
      @(negedge clk); chk("msb sel start", sel1, 15);
      at_cycle(n + 8);
      @(negedge clk); chk("msb sel mid", sel1, 8);
      at_cycle(n + 16);
      @(negedge clk); chk("msb sel end", sel1, 0);
      at_cycle(n + 17);
      @(negedge clk); chk("msb done", done1, 1);
      at_cycle(n + 18);
      @(negedge clk);
      chk("msb ready", ready1, 1);
      chk("msb sel restart", sel1, 15);
      at_cycle(n + 22);
      chk("msb queue drained", q1.size(), 0);
      chk("final queue0 drained", q0.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
